joy_db15_tx: RTL and testbench
==============================

# joy_db15_tx

Device-side serializer for the DB15 UserIO joystick link. It emulates the adapter's parallel-load shift-register chain. It latches two 12-button joystick words while the host holds `JOY_LOAD` low, then shifts them out on `JOY_DATA`, one bit per rising `JOY_CLK` edge. It sits at the far end of the link from the host-side DB15 reader and is used in bench models and in cores that act as a joystick adapter.

## Interface

Parameters:
- `FRAME_BITS`, 24 — bits per frame: P1 word then P2 word.
- `SYNC_STAGES`, 2 — flip-flop stages on `JOY_CLK` and `JOY_LOAD`.
- `TIMEOUT`, 50000 — `clk` cycles without a `JOY_LOAD` fall before `link_idle` asserts.

Ports:
- `clk` in 1 — system clock, 40–50 MHz.
- `reset_n` in 1 — reset, asynchronous, active-low.
- `joystick1` in 12 — P1 buttons, active-high pressed; bit 0 is sent first.
- `joystick2` in 12 — P2 buttons, active-high pressed.
- `JOY_CLK` in 1 — host shift clock, asynchronous to `clk`.
- `JOY_LOAD` in 1 — host load strobe, active-low, asynchronous to `clk`.
- `JOY_DATA` out 1 — serial data, active-low (0 = pressed), idle 1.
- `frame_done` out 1 — one-cycle pulse when the last frame bit is consumed.
- `bit_cnt` out 5 — shift edges taken in the current frame; saturates at `FRAME_BITS`.
- `overrun` out 1 — sticky; a shift edge arrived after a complete frame.
- `link_idle` out 1 — no `JOY_LOAD` fall within `TIMEOUT` cycles.

## Operation

- **Input sync and edge detect**
  - `JOY_CLK` and `JOY_LOAD` each pass through `SYNC_STAGES` flip-flops, then one edge-detect register.
  - `clk_rise` = synced `JOY_CLK` 0→1.
  - `load_fall` = synced `JOY_LOAD` 1→0.
- **Shift register**
  - Width `FRAME_BITS`, register `sr`.
  - Load: while synced `JOY_LOAD` = 0, every cycle `sr <= ~{joystick2, joystick1}` and `bit_cnt <= 0`. The register tracks live inputs during load, like a 74HC165.
  - `clk_rise` while synced `JOY_LOAD` = 0 is ignored.
  - Shift: on `clk_rise` while synced `JOY_LOAD` = 1:
    - `sr <= {1'b1, sr[FRAME_BITS-1:1]}`; ones fill from the top.
    - If `bit_cnt < FRAME_BITS`: `bit_cnt` increments.
    - If the increment makes `bit_cnt == FRAME_BITS`: pulse `frame_done`.
    - If `bit_cnt == FRAME_BITS` already: set `overrun`; `bit_cnt` holds.
  - `JOY_DATA` is registered as `sr[0]` (one `clk` after `sr` updates).
- **Overrun:** cleared only while synced `JOY_LOAD` = 0.
- **Idle watchdog**
  - 16-bit counter cleared on `load_fall`; otherwise increments, saturating at `TIMEOUT`.
  - `link_idle` = (counter == `TIMEOUT`).
- **Widths:** joystick inputs are 12 bits each, which requires `FRAME_BITS` = 24. For any other `FRAME_BITS`, the inputs are zero-extended at the top (shifted as 1 = released), or truncated from the top.

## Timing

- **Reset** (`reset_n` = 0, asynchronous):
  - `sr` all 1; `JOY_DATA` = 1; `bit_cnt` = 0.
  - `frame_done` = 0; `overrun` = 0.
  - Watchdog counter = `TIMEOUT`, so `link_idle` = 1.
  - Sync chains reset to `JOY_CLK` = 0, `JOY_LOAD` = 1.
- **Reset mid-frame:** frame is aborted. After release, the first `clk_rise` shifts the all-ones `sr`, so `JOY_DATA` stays 1 until the next load.
- **Latency from pin edge to `JOY_DATA` change:** `SYNC_STAGES` + 2 `clk` cycles, i.e. 4 with defaults.
  - Pin edge to `frame_done`, `bit_cnt`, and `overrun` update: `SYNC_STAGES` + 1 cycles.
- **Host requirements:**
  - `JOY_CLK` high and low phases each ≥ `SYNC_STAGES` + 1 `clk` cycles.
  - Host samples `JOY_DATA` ≥ `SYNC_STAGES` + 2 cycles after its previous `JOY_CLK` rise.
  - `JOY_LOAD` low ≥ 2 `clk` cycles.
- **Simultaneous events:**
  - Synced `JOY_LOAD` = 0 and `clk_rise` in the same cycle: load wins; no shift; `bit_cnt` = 0.
  - `JOY_LOAD` rises in the same cycle as `clk_rise`: shift uses the new (high) `JOY_LOAD` value, so the shift is taken.
- **Frame length:**
  - After a load, `JOY_DATA` presents bit 0 before any clock edge.
  - The 23rd `clk_rise` presents bit 23.
  - The 24th `clk_rise` presents 1 (fill) and pulses `frame_done`.
- **Watchdog:** `link_idle` falls 1 cycle after `load_fall`. It rises exactly `TIMEOUT` cycles after the last `load_fall`, and it wraps never (counter saturates).

## Test plan

- **Reset values:** assert `reset_n` low mid-frame → immediately `JOY_DATA` = 1, `bit_cnt` = 0, `overrun` = 0, `link_idle` = 1, `frame_done` = 0.
- **Full frame:** `joystick1` = 12'h005, `joystick2` = 12'h800; pulse `JOY_LOAD`, then 24 `JOY_CLK` pulses (8-cycle phases).
  - Sampled `JOY_DATA` sequence bits 0..23 = 0,1,0,1, then 1×19, then 0.
  - `frame_done` pulses once, on the 24th edge; `bit_cnt` = 24.
- **Overrun:** 26 clocks after a load → `overrun` = 1 from the 25th edge, `bit_cnt` = 24, `JOY_DATA` = 1. Next `JOY_LOAD` low → `overrun` = 0.
- **Live load tracking:** hold `JOY_LOAD` low and toggle `joystick1[0]` → `JOY_DATA` follows inverted within `SYNC_STAGES` + 2 cycles. `JOY_CLK` pulses during load leave `bit_cnt` = 0.
- **Load/clock collision:** `JOY_LOAD` fall coincident with a `JOY_CLK` rise mid-frame → `bit_cnt` = 0, `JOY_DATA` = ~`joystick1[0]`, no `frame_done`.
- **Watchdog:** with `TIMEOUT` = 100, loads every 80 cycles → `link_idle` stays 0. Stop loads → `link_idle` = 1 exactly 100 cycles after the last `load_fall`.

Source files
------------

// File: rtl/joy_db15_tx_if.sv
// DB15 UserIO joystick link pins: host drives shift clock and load strobe,
// the adapter side returns the serial button stream.
interface joy_db15_tx_if;
  logic JOY_CLK;
  logic JOY_LOAD;
  logic JOY_DATA;

  modport master (
    output JOY_CLK,
    output JOY_LOAD,
    input  JOY_DATA
  );

  modport slave (
    input  JOY_CLK,
    input  JOY_LOAD,
    output JOY_DATA
  );
endinterface

// File: rtl/joy_db15_tx.sv
// Adapter-side DB15 joystick serializer: emulates a parallel-load shift chain
// that latches both 12-button words on JOY_LOAD low and shifts on JOY_CLK rises.
module joy_db15_tx #(
  parameter int FRAME_BITS  = 24,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 50000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [11:0]         joystick1,
  input  logic [11:0]         joystick2,
  joy_db15_tx_if.slave        link,
  output logic                frame_done,
  output logic [4:0]          bit_cnt,
  output logic                overrun,
  output logic                link_idle
);

  localparam int         JOY_BITS   = 24;
  localparam logic [4:0] FRAME_LEN  = 5'(FRAME_BITS);
  localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] load_sync;
  logic                   clk_prev;
  logic                   load_prev;
  logic                   clk_s;
  logic                   load_s;
  logic                   clk_rise;
  logic                   load_fall;

  logic [JOY_BITS-1:0]    joy_word;
  logic [FRAME_BITS-1:0]  frame_word;
  logic [FRAME_BITS-1:0]  sr;
  logic [15:0]            idle_cnt;

  // Host pins are asynchronous; chains reset to the idle pin levels (clock low,
  // load high) so releasing reset never fakes an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '0;
      load_sync <= '1;
      clk_prev  <= 1'b0;
      load_prev <= 1'b1;
    end else begin
      clk_sync[0]  <= link.JOY_CLK;
      load_sync[0] <= link.JOY_LOAD;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        clk_sync[i]  <= clk_sync[i-1];
        load_sync[i] <= load_sync[i-1];
      end
      clk_prev  <= clk_s;
      load_prev <= load_s;
    end
  end

  assign clk_s     = clk_sync[SYNC_STAGES-1];
  assign load_s    = load_sync[SYNC_STAGES-1];
  assign clk_rise  = clk_s & ~clk_prev;
  assign load_fall = ~load_s & load_prev;

  assign joy_word = {joystick2, joystick1};

  // Unused upper frame bits load as released (zero before inversion).
  generate
    if (FRAME_BITS > JOY_BITS) begin : g_extend
      assign frame_word = {{(FRAME_BITS-JOY_BITS){1'b0}}, joy_word};
    end else begin : g_trunc
      assign frame_word = joy_word[FRAME_BITS-1:0];
    end
  endgenerate

  // Load is level-sensitive and tracks live buttons, so it outranks any shift
  // edge seen in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr         <= '1;
      bit_cnt    <= 5'd0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!load_s) begin
        sr      <= ~frame_word;
        bit_cnt <= 5'd0;
        overrun <= 1'b0;
      end else if (clk_rise) begin
        sr <= {1'b1, sr[FRAME_BITS-1:1]};
        if (bit_cnt < FRAME_LEN) begin
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == FRAME_LEN - 5'd1) begin
            frame_done <= 1'b1;
          end
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      link.JOY_DATA <= 1'b1;
    end else begin
      link.JOY_DATA <= sr[0];
    end
  end

  // Watchdog saturates rather than wrapping so a dead link stays reported.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= IDLE_LIMIT;
    end else if (load_fall) begin
      idle_cnt <= 16'd0;
    end else if (idle_cnt != IDLE_LIMIT) begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign link_idle = (idle_cnt == IDLE_LIMIT);

endmodule

// File: tb/tb_joy_db15_tx.sv
// Scoreboard bench for joy_db15_tx: expected serial bits are queued at load
// time and popped as each host shift clock is applied.
module tb_joy_db15_tx;
  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] joystick1 = 12'h000;
  logic [11:0] joystick2 = 12'h000;
  logic        frame_done;
  logic [4:0]  bit_cnt;
  logic        overrun;
  logic        link_idle;

  int n_checks = 0;
  int n_fail = 0;
  int done_count = 0;
  logic exp_q[$];

  joy_db15_tx_if link ();

  joy_db15_tx #(
    .FRAME_BITS(24),
    .SYNC_STAGES(2),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .joystick1(joystick1),
    .joystick2(joystick2),
    .link(link),
    .frame_done(frame_done),
    .bit_cnt(bit_cnt),
    .overrun(overrun),
    .link_idle(link_idle)
  );

  always #5 clk = ~clk;

  // Count frame_done pulses as seen by the active edge.
  always @(posedge clk) begin
    if (frame_done === 1'b1) done_count <= done_count + 1;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clk_pulse();
    link.JOY_CLK = 1'b1;
    cycles(8);
    link.JOY_CLK = 1'b0;
    cycles(8);
  endtask

  task automatic do_load();
    link.JOY_LOAD = 1'b0;
    cycles(8);
    link.JOY_LOAD = 1'b1;
    cycles(8);
  endtask

  task automatic push_frame(input logic [11:0] j1, input logic [11:0] j2);
    logic [23:0] f;
    f = {j2, j1};
    exp_q.delete();
    for (int i = 0; i < 24; i++) exp_q.push_back(~f[i]);
    exp_q.push_back(1'b1);
  endtask

  task automatic test_power_on();
    n_checks++;
    if (link.JOY_DATA !== 1'b1) begin n_fail++; $display("[TB] FAIL por_data: got %b expected 1", link.JOY_DATA); end
    n_checks++;
    if (bit_cnt !== 5'd0) begin n_fail++; $display("[TB] FAIL por_bit_cnt: got %0d expected 0", bit_cnt); end
    n_checks++;
    if (link_idle !== 1'b1) begin n_fail++; $display("[TB] FAIL por_idle: got %b expected 1", link_idle); end
    n_checks++;
    if (overrun !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("[TB] FAIL por_flags: got ovr=%b done=%b expected 0/0", overrun, frame_done);
    end
  endtask

  task automatic test_full_frame();
    logic exp;
    int   d0;
    joystick1 = 12'h005;
    joystick2 = 12'h800;
    push_frame(joystick1, joystick2);
    do_load();
    exp = exp_q.pop_front();
    n_checks++;
    if (link.JOY_DATA !== exp) begin n_fail++; $display("[TB] FAIL frame_bit0: got %b expected %b", link.JOY_DATA, exp); end
    n_checks++;
    if (bit_cnt !== 5'd0) begin n_fail++; $display("[TB] FAIL frame_cnt0: got %0d expected 0", bit_cnt); end
    d0 = done_count;
    for (int i = 1; i <= 24; i++) begin
      clk_pulse();
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
      n_checks++;
      if (link.JOY_DATA !== exp) begin n_fail++; $display("[TB] FAIL frame_data[%0d]: got %b expected %b", i, link.JOY_DATA, exp); end
      n_checks++;
      if (bit_cnt !== 5'(i)) begin n_fail++; $display("[TB] FAIL frame_cnt[%0d]: got %0d expected %0d", i, bit_cnt, i); end
      n_checks++;
      if (done_count - d0 !== ((i == 24) ? 1 : 0)) begin
        n_fail++; $display("[TB] FAIL frame_done[%0d]: got %0d pulses expected %0d", i, done_count - d0, (i == 24) ? 1 : 0);
      end
    end
  endtask

  task automatic test_overrun();
    logic exp;
    int   d0;
    joystick1 = 12'hA5A;
    joystick2 = 12'h3C3;
    push_frame(joystick1, joystick2);
    do_load();
    void'(exp_q.pop_front());
    d0 = done_count;
    for (int i = 1; i <= 26; i++) begin
      clk_pulse();
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
      n_checks++;
      if (link.JOY_DATA !== exp) begin n_fail++; $display("[TB] FAIL ovr_data[%0d]: got %b expected %b", i, link.JOY_DATA, exp); end
      n_checks++;
      if (overrun !== (i >= 25)) begin n_fail++; $display("[TB] FAIL ovr_flag[%0d]: got %b expected %b", i, overrun, i >= 25); end
      n_checks++;
      if (bit_cnt !== 5'((i > 24) ? 24 : i)) begin
        n_fail++; $display("[TB] FAIL ovr_cnt[%0d]: got %0d expected %0d", i, bit_cnt, (i > 24) ? 24 : i);
      end
    end
    n_checks++;
    if (done_count - d0 !== 1) begin n_fail++; $display("[TB] FAIL ovr_done_count: got %0d expected 1", done_count - d0); end
    link.JOY_LOAD = 1'b0;
    cycles(8);
    n_checks++;
    if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL ovr_clear: got %b expected 0", overrun); end
    n_checks++;
    if (bit_cnt !== 5'd0) begin n_fail++; $display("[TB] FAIL ovr_cnt_clear: got %0d expected 0", bit_cnt); end
    link.JOY_LOAD = 1'b1;
    cycles(8);
  endtask

  task automatic test_live_load();
    joystick1 = 12'h000;
    joystick2 = 12'h000;
    link.JOY_LOAD = 1'b0;
    cycles(8);
    n_checks++;
    if (link.JOY_DATA !== 1'b1) begin n_fail++; $display("[TB] FAIL live_idle: got %b expected 1", link.JOY_DATA); end
    joystick1[0] = 1'b1;
    cycles(4);
    n_checks++;
    if (link.JOY_DATA !== 1'b0) begin n_fail++; $display("[TB] FAIL live_press: got %b expected 0", link.JOY_DATA); end
    joystick1[0] = 1'b0;
    cycles(4);
    n_checks++;
    if (link.JOY_DATA !== 1'b1) begin n_fail++; $display("[TB] FAIL live_release: got %b expected 1", link.JOY_DATA); end
    joystick1[0] = 1'b1;
    clk_pulse();
    clk_pulse();
    n_checks++;
    if (bit_cnt !== 5'd0) begin n_fail++; $display("[TB] FAIL live_clk_ignored: got %0d expected 0", bit_cnt); end
    n_checks++;
    if (link.JOY_DATA !== 1'b0) begin n_fail++; $display("[TB] FAIL live_data_held: got %b expected 0", link.JOY_DATA); end
    link.JOY_LOAD = 1'b1;
    cycles(8);
  endtask

  task automatic test_collision();
    int d0;
    joystick1 = 12'h001;
    joystick2 = 12'h000;
    do_load();
    repeat (5) clk_pulse();
    n_checks++;
    if (bit_cnt !== 5'd5 || link.JOY_DATA !== 1'b1) begin
      n_fail++; $display("[TB] FAIL coll_pre: got cnt=%0d data=%b expected 5/1", bit_cnt, link.JOY_DATA);
    end
    d0 = done_count;
    link.JOY_LOAD = 1'b0;
    link.JOY_CLK = 1'b1;
    cycles(8);
    n_checks++;
    if (bit_cnt !== 5'd0) begin n_fail++; $display("[TB] FAIL coll_cnt: got %0d expected 0", bit_cnt); end
    n_checks++;
    if (link.JOY_DATA !== ~joystick1[0]) begin n_fail++; $display("[TB] FAIL coll_data: got %b expected %b", link.JOY_DATA, ~joystick1[0]); end
    link.JOY_CLK = 1'b0;
    cycles(8);
    n_checks++;
    if (done_count !== d0) begin n_fail++; $display("[TB] FAIL coll_done: got %0d pulses expected 0", done_count - d0); end
    // Load release and shift edge arriving together: the shift must be taken.
    link.JOY_LOAD = 1'b1;
    link.JOY_CLK = 1'b1;
    cycles(8);
    n_checks++;
    if (bit_cnt !== 5'd1 || link.JOY_DATA !== 1'b1) begin
      n_fail++; $display("[TB] FAIL rise_shift: got cnt=%0d data=%b expected 1/1", bit_cnt, link.JOY_DATA);
    end
    link.JOY_CLK = 1'b0;
    cycles(8);
  endtask

  task automatic test_reset();
    joystick1 = 12'hFFF;
    joystick2 = 12'hFFF;
    do_load();
    repeat (5) clk_pulse();
    n_checks++;
    if (link.JOY_DATA !== 1'b0 || bit_cnt !== 5'd5 || link_idle !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_pre: got data=%b cnt=%0d idle=%b expected 0/5/0", link.JOY_DATA, bit_cnt, link_idle);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (link.JOY_DATA !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_data: got %b expected 1", link.JOY_DATA); end
    n_checks++;
    if (bit_cnt !== 5'd0) begin n_fail++; $display("[TB] FAIL rst_cnt: got %0d expected 0", bit_cnt); end
    n_checks++;
    if (link_idle !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_idle: got %b expected 1", link_idle); end
    n_checks++;
    if (overrun !== 1'b0 || frame_done !== 1'b0) begin
      n_fail++; $display("[TB] FAIL rst_flags: got ovr=%b done=%b expected 0/0", overrun, frame_done);
    end
    cycles(3);
    reset_n = 1'b1;
    cycles(4);
    clk_pulse();
    n_checks++;
    if (link.JOY_DATA !== 1'b1 || bit_cnt !== 5'd1) begin
      n_fail++; $display("[TB] FAIL rst_after_shift: got data=%b cnt=%0d expected 1/1", link.JOY_DATA, bit_cnt);
    end
  endtask

  task automatic test_watchdog();
    int idle_seen;
    for (int p = 0; p < 4; p++) begin
      idle_seen = 0;
      link.JOY_LOAD = 1'b0;
      for (int k = 1; k <= 80; k++) begin
        @(negedge clk);
        if (k >= 3 && link_idle !== 1'b0) idle_seen++;
        if (k == 4) link.JOY_LOAD = 1'b1;
      end
      n_checks++;
      if (idle_seen !== 0) begin n_fail++; $display("[TB] FAIL wd_period[%0d]: got %0d idle cycles expected 0", p, idle_seen); end
    end
    link.JOY_LOAD = 1'b0;
    for (int k = 1; k <= 103; k++) begin
      @(negedge clk);
      if (k == 4) link.JOY_LOAD = 1'b1;
      if (k == 3 || k == 102) begin
        n_checks++;
        if (link_idle !== 1'b0) begin n_fail++; $display("[TB] FAIL wd_low[%0d]: got %b expected 0", k, link_idle); end
      end
      if (k == 103) begin
        n_checks++;
        if (link_idle !== 1'b1) begin n_fail++; $display("[TB] FAIL wd_rise: got %b expected 1", link_idle); end
      end
    end
  endtask

  initial begin
    link.JOY_CLK  = 1'b0;
    link.JOY_LOAD = 1'b1;
    reset_n = 1'b0;
    cycles(3);
    test_power_on();
    reset_n = 1'b1;
    cycles(4);
    test_full_frame();
    test_overrun();
    test_live_load();
    test_collision();
    test_reset();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
